// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 timing constants and axis state encoding
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } axis_state_t;

endpackage

// File: rtl/vga_axis_timer.sv
// rtl/vga_axis_timer.sv - one timing axis: wrapping counter plus ACTIVE/FRONT/SYNC/BACK FSM
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int ACT_LEN  = DEF_H_ACTIVE,
  parameter int FP_LEN   = DEF_H_FP,
  parameter int SYNC_LEN = DEF_H_SYNC,
  parameter int BP_LEN   = DEF_H_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output axis_state_t      state,
  output logic             last
);

  localparam logic [CNT_W-1:0] A_END = CNT_W'(ACT_LEN);
  localparam logic [CNT_W-1:0] F_END = CNT_W'(ACT_LEN + FP_LEN);
  localparam logic [CNT_W-1:0] S_END = CNT_W'(ACT_LEN + FP_LEN + SYNC_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(ACT_LEN + FP_LEN + SYNC_LEN + BP_LEN - 1);

  logic [CNT_W-1:0] cnt_nxt;

  assign last    = (cnt == LAST);
  assign cnt_nxt = cnt + 1'b1;

  // State is updated together with the count so it always describes cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      state <= ACTIVE;
    end else if (step) begin
      if (last) begin
        cnt   <= '0;
        state <= ACTIVE;
      end else begin
        cnt <= cnt_nxt;
        case (state)
          ACTIVE:  if (cnt_nxt == A_END) state <= FRONT;
          FRONT:   if (cnt_nxt == F_END) state <= SYNC;
          SYNC:    if (cnt_nxt == S_END) state <= BACK;
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA sync/pixel timing with per-line prefetch request and underrun flag
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk_25,
  input  logic             rst,
  input  logic             en,
  input  logic             line_ack,
  input  logic             clr_underrun,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start,
  output logic             line_req,
  output logic [CNT_W-1:0] line_num,
  output logic             underrun
);

  localparam logic [CNT_W-1:0] H_REQ_AT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LINES  = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] h_cnt, v_cnt, nxt_line;
  axis_state_t      h_state, v_state;
  logic             h_last, v_last, h_wrap, visible, underrun_set;

  vga_axis_timer #(
    .ACT_LEN (H_ACTIVE),
    .FP_LEN  (H_FP),
    .SYNC_LEN(H_SYNC),
    .BP_LEN  (H_BP)
  ) u_h_timer (
    .clk  (clk_25),
    .rst  (rst),
    .step (en),
    .cnt  (h_cnt),
    .state(h_state),
    .last (h_last)
  );

  vga_axis_timer #(
    .ACT_LEN (V_ACTIVE),
    .FP_LEN  (V_FP),
    .SYNC_LEN(V_SYNC),
    .BP_LEN  (V_BP)
  ) u_v_timer (
    .clk  (clk_25),
    .rst  (rst),
    .step (h_wrap),
    .cnt  (v_cnt),
    .state(v_state),
    .last (v_last)
  );

  assign h_wrap       = en && h_last;
  assign nxt_line     = v_last ? '0 : v_cnt + 1'b1;
  assign visible      = (h_state == ACTIVE) && (v_state == ACTIVE);
  // An ack arriving in the wrap cycle still counts as a timely acceptance.
  assign underrun_set = h_wrap && line_req && !line_ack;

  always_ff @(posedge clk_25) begin
    if (rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
      line_req    <= 1'b0;
      line_num    <= '0;
      underrun    <= 1'b0;
    end else begin
      if (en) begin
        hsync       <= (h_state != SYNC);
        vsync       <= (v_state != SYNC);
        video_on    <= visible;
        pixel_x     <= visible ? h_cnt : '0;
        pixel_y     <= visible ? v_cnt : '0;
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
        if (h_wrap) begin
          line_req <= 1'b0;
        end else if ((h_cnt == H_REQ_AT) && (nxt_line < V_LINES)) begin
          line_req <= 1'b1;
          line_num <= nxt_line;
        end else if (line_ack) begin
          line_req <= 1'b0;
        end
      end else begin
        video_on    <= 1'b0;
        pixel_x     <= '0;
        pixel_y     <= '0;
        frame_start <= 1'b0;
      end
      if (underrun_set) begin
        underrun <= 1'b1;
      end else if (clr_underrun) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - scoreboard bench: default 640x480 instance plus a tiny-frame instance
module tb_vga_timing_ctrl;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vid;
    logic [9:0] px;
    logic [9:0] py;
    logic       fs;
    logic       lreq;
    logic [9:0] lnum;
    logic       und;
  } out_t;

  typedef struct packed {
    int   h;
    int   v;
    out_t o;
  } mst_t;

  logic clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;

  logic       b_rst, b_en, b_ack, b_clr;
  logic       b_hsync, b_vsync, b_video_on, b_frame_start, b_line_req, b_underrun;
  logic [9:0] b_pixel_x, b_pixel_y, b_line_num;
  logic       s_rst, s_en, s_ack, s_clr;
  logic       s_hsync, s_vsync, s_video_on, s_frame_start, s_line_req, s_underrun;
  logic [9:0] s_pixel_x, s_pixel_y, s_line_num;

  vga_timing_ctrl dut (
    .clk_25(clk_25), .rst(b_rst), .en(b_en), .line_ack(b_ack), .clr_underrun(b_clr),
    .hsync(b_hsync), .vsync(b_vsync), .video_on(b_video_on), .pixel_x(b_pixel_x),
    .pixel_y(b_pixel_y), .frame_start(b_frame_start), .line_req(b_line_req),
    .line_num(b_line_num), .underrun(b_underrun)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .clk_25(clk_25), .rst(s_rst), .en(s_en), .line_ack(s_ack), .clr_underrun(s_clr),
    .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on), .pixel_x(s_pixel_x),
    .pixel_y(s_pixel_y), .frame_start(s_frame_start), .line_req(s_line_req),
    .line_num(s_line_num), .underrun(s_underrun)
  );

  out_t b_obs, s_obs;
  assign b_obs = {b_hsync, b_vsync, b_video_on, b_pixel_x, b_pixel_y, b_frame_start,
                  b_line_req, b_line_num, b_underrun};
  assign s_obs = {s_hsync, s_vsync, s_video_on, s_pixel_x, s_pixel_y, s_frame_start,
                  s_line_req, s_line_num, s_underrun};

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  out_t exp_q_b[$];
  out_t exp_q_s[$];
  int   fall_q[$];
  int   lnum_q[$];
  mst_t mb, ms;

  logic hs_track = 1'b0, st_track = 1'b0, prev_hs = 1'b1, prev_lreq = 1'b0, held;
  int   fall_cyc = 0, fs_cnt = 0, vs_low = 0, vid_cnt = 0, lreq_cnt = 0, lreq_len = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour, derived from counter ranges rather than state machines.
  function automatic void mstep(input int ha, hf, hs, hb, va, vf, vs, vb,
                                input logic rst, en, ack, clr, inout mst_t s);
    int   ht, vt, nxt;
    logic set;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    set = 1'b0;
    if (rst) begin
      s.h = 0; s.v = 0; s.o = '0; s.o.hs = 1'b1; s.o.vs = 1'b1;
      return;
    end
    if (en) begin
      s.o.hs  = !((s.h >= ha + hf) && (s.h < ha + hf + hs));
      s.o.vs  = !((s.v >= va + vf) && (s.v < va + vf + vs));
      s.o.vid = (s.h < ha) && (s.v < va);
      s.o.px  = s.o.vid ? 10'(s.h) : 10'd0;
      s.o.py  = s.o.vid ? 10'(s.v) : 10'd0;
      s.o.fs  = (s.h == 0) && (s.v == 0);
      nxt = (s.v + 1) % vt;
      if (s.h == ht - 1) begin
        set = s.o.lreq && !ack;
        s.o.lreq = 1'b0;
      end else if (s.h == ha && nxt < va) begin
        s.o.lreq = 1'b1;
        s.o.lnum = 10'(nxt);
      end else if (ack) begin
        s.o.lreq = 1'b0;
      end
      s.h = s.h + 1;
      if (s.h == ht) begin
        s.h = 0;
        s.v = (s.v + 1) % vt;
      end
    end else begin
      s.o.vid = 1'b0; s.o.px = '0; s.o.py = '0; s.o.fs = 1'b0;
    end
    if (set) s.o.und = 1'b1;
    else if (clr) s.o.und = 1'b0;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      mstep(640, 16, 96, 48, 480, 10, 2, 33, b_rst, b_en, b_ack, b_clr, mb);
      exp_q_b.push_back(mb.o);
      mstep(8, 2, 3, 2, 6, 1, 2, 2, s_rst, s_en, s_ack, s_clr, ms);
      exp_q_s.push_back(ms.o);
      @(posedge clk_25);
      #1;
      cyc++;
      chk("big_outputs", 64'(b_obs), 64'(exp_q_b.pop_front()));
      chk("small_outputs", 64'(s_obs), 64'(exp_q_s.pop_front()));
      if (hs_track) begin
        if (prev_hs && !b_hsync) begin
          fall_cyc = cyc;
          if (fall_q.size() > 0) chk("hsync_fall_cycle", cyc, fall_q.pop_front());
          else chk("hsync_fall_unexpected", cyc, 0);
        end
        if (!prev_hs && b_hsync) chk("hsync_low_width", cyc - fall_cyc, 96);
      end
      prev_hs = b_hsync;
      if (st_track) begin
        fs_cnt  += int'(s_frame_start);
        vs_low  += int'(!s_vsync);
        vid_cnt += int'(s_video_on);
        if (s_line_req && !prev_lreq) begin
          lreq_cnt++;
          lreq_len = 0;
          if (lnum_q.size() > 0) chk("line_num_order", s_line_num, lnum_q.pop_front());
          else chk("line_req_unexpected", s_line_num, 10'h3ff);
        end
        if (s_line_req) lreq_len++;
        if (!s_line_req && prev_lreq) chk("line_req_len_1_or_2", (lreq_len >= 1 && lreq_len <= 2), 1);
      end
      prev_lreq = s_line_req;
    end
  endtask

  initial begin
    b_rst = 1'b1; b_en = 1'b0; b_ack = 1'b0; b_clr = 1'b0;
    s_rst = 1'b1; s_en = 1'b0; s_ack = 1'b0; s_clr = 1'b0;
    mb = '0; ms = '0;
    step(2);
    chk("rst_hsync", b_hsync, 1);
    chk("rst_vsync", b_vsync, 1);
    chk("rst_line_req", b_line_req, 0);
    chk("rst_underrun", b_underrun, 0);
    chk("rst_pixel_x", b_pixel_x, 0);

    // hsync timing from reset release
    for (int k = 0; k < 5; k++) fall_q.push_back(657 + 800 * k);
    b_rst = 1'b0; b_en = 1'b1; b_ack = 1'b1; cyc = 0; hs_track = 1'b1; prev_hs = 1'b1;
    step(4101);
    hs_track = 1'b0;
    chk("hsync_falls_seen", fall_q.size(), 0);
    chk("pre_gap_pixel_x", b_pixel_x, 100);
    chk("pre_gap_pixel_y", b_pixel_y, 5);

    // enable gap
    held = b_hsync;
    b_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("gap_video_on", b_video_on, 0);
      chk("gap_hsync_hold", b_hsync, held);
    end
    b_en = 1'b1;
    step(1);
    chk("resume_pixel_x", b_pixel_x, 101);
    chk("resume_pixel_y", b_pixel_y, 5);

    // underrun with line_ack held low
    b_rst = 1'b1; step(1);
    b_rst = 1'b0; b_ack = 1'b0;
    step(641);
    chk("first_req", b_line_req, 1);
    chk("first_req_line", b_line_num, 1);
    step(158);
    chk("underrun_before_wrap", b_underrun, 0);
    chk("req_pending_at_wrap", b_line_req, 1);
    step(1);
    chk("underrun_set", b_underrun, 1);
    chk("req_dropped_at_wrap", b_line_req, 0);
    b_clr = 1'b1; step(1); b_clr = 1'b0;
    chk("underrun_cleared", b_underrun, 0);
    step(798);
    chk("underrun_still_clear", b_underrun, 0);
    b_clr = 1'b1; step(1); b_clr = 1'b0;
    chk("underrun_set_beats_clear", b_underrun, 1);
    step(1);
    chk("underrun_sticky", b_underrun, 1);

    // full small frame with line_ack high
    b_rst = 1'b1;
    for (int k = 1; k < 6; k++) lnum_q.push_back(k);
    lnum_q.push_back(0);
    s_rst = 1'b0; s_en = 1'b1; s_ack = 1'b1; st_track = 1'b1; prev_lreq = 1'b0;
    step(165);
    st_track = 1'b0;
    chk("frame_start_count", fs_cnt, 1);
    chk("vsync_low_cycles", vs_low, 30);
    chk("video_on_cycles", vid_cnt, 48);
    chk("line_req_pulses", lreq_cnt, 6);
    chk("line_nums_consumed", lnum_q.size(), 0);

    // reset mid-frame with a request pending
    s_ack = 1'b0;
    step(57);
    chk("pending_before_rst", s_line_req, 1);
    s_rst = 1'b1; step(1);
    chk("midrst_line_req", s_line_req, 0);
    chk("midrst_line_num", s_line_num, 0);
    chk("midrst_hsync", s_hsync, 1);
    chk("midrst_underrun", s_underrun, 0);
    s_rst = 1'b0; step(1);
    chk("restart_frame_start", s_frame_start, 1);
    chk("restart_video_on", s_video_on, 1);
    chk("restart_pixel_xy", {s_pixel_x, s_pixel_y}, 0);
    step(1);
    chk("restart_pixel_x1", s_pixel_x, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameters SHALL be given one per line as name, default, meaning:
  H_ACTIVE, 640, visible pixels per line
  H_FP, 16, horizontal front porch
  H_SYNC, 96, hsync width
  H_BP, 48, horizontal back porch
  V_ACTIVE, 480, visible lines per frame
  V_FP, 10, vertical front porch
  V_SYNC, 2, vsync width
  V_BP, 33, vertical back porch
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk_25  in  1  pixel clock; the only clock
  rst  in  1  reset; synchronous, active-high
  en  in  1  timing advance enable
  line_ack  in  1  pixel source accepted line_req
  clr_underrun  in  1  clears underrun
  hsync  out  1  horizontal sync, active-low
  vsync  out  1  vertical sync, active-low
  video_on  out  1  high during the visible pixel
  pixel_x  out  10  column; 0 when blanked
  pixel_y  out  10  row; 0 when blanked
  frame_start  out  1  one-cycle pulse at pixel (0,0)
  line_req  out  1  request to prefetch line line_num
  line_num  out  10  line being requested
  underrun  out  1  sticky; a line was not acked in time

Function
REQ-003 Internal h_cnt SHALL count 0..H_TOTAL-1 (800) and SHALL wrap to 0; v_cnt SHALL advance only on the h_cnt wrap, counting 0..V_TOTAL-1 (525) and wrapping to 0.
REQ-004 When en=0, both counters and line_req SHALL hold, video_on SHALL be 0, and hsync/vsync SHALL hold.
REQ-005 Each axis SHALL run an FSM with states ACTIVE, FRONT, SYNC and BACK.
  - ACTIVE to FRONT at cnt=ACTIVE.
  - FRONT to SYNC at cnt=ACTIVE+FP.
  - SYNC to BACK at cnt=ACTIVE+FP+SYNC.
  - BACK to ACTIVE at the wrap.
REQ-006 All outputs SHALL be registered and SHALL reflect the counter value of the previous cycle, giving a latency of 1 cycle.
REQ-007 hsync SHALL be 0 iff the h FSM is in SYNC (h 656..751); vsync SHALL be 0 iff the v FSM is in SYNC (v 490..491).
REQ-008 video_on SHALL be 1 iff both FSMs are in ACTIVE and en=1; pixel_x=h_cnt and pixel_y=v_cnt when video_on=1, otherwise both SHALL be 0.
REQ-009 frame_start SHALL pulse for 1 cycle when h_cnt=0, v_cnt=0 and en=1.
REQ-010 At h_cnt=H_ACTIVE, if the next line nxt=(v_cnt+1) mod 525 is below V_ACTIVE, line_req SHALL rise with line_num=nxt.
REQ-011 line_req SHALL stay high until line_ack is sampled high, and SHALL clear on the following cycle; line_num SHALL stay stable while line_req=1.
REQ-012 If line_req is still 1 when h_cnt wraps to 0, underrun SHALL set and line_req SHALL clear.
  - line_ack in that same cycle counts as accepted; no underrun is flagged.
REQ-013 underrun SHALL clear only on clr_underrun=1; if a set and a clear occur in the same cycle, the set wins.
REQ-014 The v_cnt=524 to 0 wrap SHALL be handled as any other line: line 0 is requested during line 524.

Reset
REQ-015 With rst=1 at a clk_25 edge, counters SHALL go to 0 and both FSMs to ACTIVE.
REQ-016 Reset output values SHALL be: hsync=1, vsync=1, video_on=0, pixel_x=0, pixel_y=0, frame_start=0, line_req=0, line_num=0, underrun=0.
REQ-017 rst SHALL override en, line_ack and clr_underrun, and SHALL abandon any pending request.

Structure
REQ-018 A shared package vga_timing_pkg SHALL hold:
  - the 640x480@60 default constants and the derived H_TOTAL=800 and V_TOTAL=525;
  - the axis state encoding (ACTIVE, FRONT, SYNC, BACK).
REQ-019 A single sub-module, vga_axis_timer, SHALL hold one parameterized counter plus FSM; it SHALL be instanced once for h and once for v, with the v instance stepped by the h wrap.

Verification
REQ-020 Release reset with en=1: hsync SHALL go low exactly at cycle 657 after release and stay low for 96 cycles, then repeat every 800 cycles.
REQ-021 Run one full frame (420000 cycles) with line_ack tied high: frame_start SHALL pulse once, vsync SHALL be low for 1600 cycles, and video_on SHALL be high for 307200 cycles.
REQ-022 Same frame as REQ-021: there SHALL be 480 line_req pulses, each 1 or 2 cycles long, with line_num 1..479 followed by 0.
REQ-023 Hold line_ack=0: underrun SHALL set at the first h wrap after the first request.
  - Pulsing clr_underrun SHALL clear it.
  - clr_underrun coinciding with the next set SHALL leave underrun=1.
REQ-024 Assert rst at h=300, v=200 with line_req pending: the next cycle SHALL show the reset values, and the counters SHALL restart at (0,0).
REQ-025 Drop en for 10 cycles at h=100, v=5: video_on SHALL be 0 and hsync hold during the gap; pixel_x SHALL resume at 101 with no skipped counts.
